// File: rtl/ex_mem_loader_pkg.sv
// ============================================================================
// Module   : ex_mem_loader_pkg
// Brief    : Shared constants and FSM state encoding for the ex_mem_loader
//            block. Configuration macro: LOADER_DUMP_EN (enables dump phase).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_loader_pkg;

    localparam int LOAD_ADDR_W    = 9;
    localparam int NUM_DEBUG_SEL  = 32;
    localparam int WORDS_PER_BEAT = 4;

    // Top-level sequencing states. The dump states exist in the encoding in
    // every build but are only reachable when the dump phase is built.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_RUN      = 3'd3,
        ST_DUMP_SEL = 3'd4,
        ST_DUMP_OUT = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_loader_if.sv
// ============================================================================
// Module   : ex_mem_loader_if
// Brief    : Host-facing streams of the loader: the load word stream (s_*)
//            flowing into the loader and the debug dump stream (m_*) flowing
//            back out. The master modport is the host side, the slave
//            modport is the loader side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

`default_nettype wire

// File: rtl/ex_mem_loader_debug_dump_seq.sv
// ============================================================================
// Module   : debug_dump_seq
// Brief    : Debug register sweep. Owns the DebugSel counter, captures the
//            core's DebugOutput one cycle after the selector settles and
//            presents it on the dump stream until the host accepts it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_dump_seq #(
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              out_phase,
    input  wire logic [DATA_W-1:0] DebugOutput,
    input  wire logic              m_ready,
    output logic                   m_valid,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_last,
    output logic [4:0]             DebugSel,
    output logic                   word_hs,
    output logic                   last_hs
);

    localparam logic [4:0] LAST_SEL = 5'(NUM_SEL - 1);

    logic [4:0]        r_sel;
    logic              r_valid;
    logic              r_last;
    logic [DATA_W-1:0] r_data;

    // Selector advance on each accepted word; capture of the settled debug value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= 5'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (r_valid && m_ready) begin
            // Returning the selector to 0 after the final word leaves the
            // block ready for the next sweep without a separate clear.
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sel   <= r_last ? 5'd0 : r_sel + 5'd1;
        end else if (out_phase && !r_valid) begin
            r_valid <= 1'b1;
            r_data  <= DebugOutput;
            r_last  <= (r_sel == LAST_SEL);
        end
    end

    assign m_valid  = r_valid;
    assign m_data   = r_data;
    assign m_last   = r_last;
    assign DebugSel = r_sel;
    assign word_hs  = r_valid & m_ready;
    assign last_hs  = r_valid & m_ready & r_last;

endmodule

`default_nettype wire

// File: rtl/ex_mem_loader.sv
// ============================================================================
// Module   : ex_mem_loader
// Brief    : Host-side driver for the core's external memory-load and debug
//            ports. Packs a host word stream into paired instruction/data
//            write beats, releases the core for a programmed cycle count,
//            then (with LOADER_DUMP_EN defined) halts it and streams out all
//            debug selector values.
// Config   : LOADER_DUMP_EN - builds the debug dump phase. When undefined the
//            sequence ends right after the run phase and the dump stream is
//            tied off.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_loader
    import ex_mem_loader_pkg::*;
#(
    parameter int ADDR_W  = LOAD_ADDR_W,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = NUM_DEBUG_SEL
) (
    input  wire logic              clk,
    input  wire logic              reset,

    input  wire logic              cmd_start,
    input  wire logic [ADDR_W:0]   cmd_pairs,
    input  wire logic [31:0]       cmd_run_cycles,

    ex_mem_loader_if.slave         bus,

    output logic                   enable_load_ex_mem,
    output logic                   enable_halt,
    output logic [ADDR_W-1:0]      InstExMemAddress,
    output logic [ADDR_W-1:0]      DataExMemAddress,
    output logic [DATA_W-1:0]      InstExMemData1,
    output logic [DATA_W-1:0]      InstExMemData2,
    output logic [DATA_W-1:0]      DataExMemData1,
    output logic [DATA_W-1:0]      DataExMemData2,
    output logic [4:0]             DebugSel,
    input  wire logic [DATA_W-1:0] DebugOutput,

    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0]      LAST_WORD = 2'(WORDS_PER_BEAT - 1);
    localparam logic [ADDR_W:0] ONE_BEAT  = (ADDR_W+1)'(1);

`ifdef LOADER_DUMP_EN
    localparam loader_state_t POST_RUN     = ST_DUMP_SEL;
    localparam logic          RUN_ENDS_SEQ = 1'b0;
`else
    localparam loader_state_t POST_RUN     = ST_IDLE;
    localparam logic          RUN_ENDS_SEQ = 1'b1;
`endif

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic              w_finish;
    logic              w_s_hs;
    logic              w_dump_hs;
    logic              w_dump_last_hs;

    logic [ADDR_W:0]   r_beats_left;
    logic [31:0]       r_run_left;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_word_idx;
    logic [DATA_W-1:0] r_inst1;
    logic [DATA_W-1:0] r_inst2;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              r_done;

    assign w_s_hs = bus.s_valid && (r_state == ST_FILL);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; w_finish marks the cycle whose exit completes a sequence
    always_comb begin
        w_next   = r_state;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_start) begin
                    if (cmd_pairs != '0) begin
                        w_next = ST_FILL;
                    end else if (cmd_run_cycles != 32'd0) begin
                        w_next = ST_RUN;
                    end else begin
                        w_next   = POST_RUN;
                        w_finish = RUN_ENDS_SEQ;
                    end
                end
            end
            ST_FILL: begin
                if (w_s_hs && (r_word_idx == LAST_WORD)) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (r_beats_left != ONE_BEAT) begin
                    w_next = ST_FILL;
                end else if (r_run_left != 32'd0) begin
                    w_next = ST_RUN;
                end else begin
                    w_next   = POST_RUN;
                    w_finish = RUN_ENDS_SEQ;
                end
            end
            ST_RUN: begin
                // Entry is only taken with a non-zero count, so 1 marks the
                // final released cycle.
                if (r_run_left == 32'd1) begin
                    w_next   = POST_RUN;
                    w_finish = RUN_ENDS_SEQ;
                end
            end
`ifdef LOADER_DUMP_EN
            ST_DUMP_SEL: begin
                w_next = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (w_dump_last_hs) begin
                    w_next   = ST_IDLE;
                    w_finish = 1'b1;
                end else if (w_dump_hs) begin
                    w_next = ST_DUMP_SEL;
                end
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Load datapath: command latch, word packing, address and count tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beats_left <= '0;
            r_run_left   <= 32'd0;
            r_addr       <= '0;
            r_word_idx   <= 2'd0;
            r_inst1      <= '0;
            r_inst2      <= '0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        r_beats_left <= cmd_pairs;
                        r_run_left   <= cmd_run_cycles;
                        r_addr       <= '0;
                        r_word_idx   <= 2'd0;
                    end
                end
                ST_FILL: begin
                    if (w_s_hs) begin
                        case (r_word_idx)
                            2'd0:    r_inst1 <= bus.s_data;
                            2'd1:    r_inst2 <= bus.s_data;
                            2'd2:    r_data1 <= bus.s_data;
                            default: r_data2 <= bus.s_data;
                        endcase
                        r_word_idx <= r_word_idx + 2'd1;
                    end
                end
                ST_WRITE: begin
                    r_beats_left <= r_beats_left - ONE_BEAT;
                    // The last beat keeps its address so the top of memory
                    // is never followed by a wrap back to 0.
                    if ((r_beats_left != ONE_BEAT) && (r_addr != '1)) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_run_left <= r_run_left - 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready         = (r_state == ST_FILL);
    assign enable_load_ex_mem  = (r_state == ST_WRITE);
    assign enable_halt         = (r_state != ST_RUN);
    assign busy                = (r_state != ST_IDLE);
    assign done                = r_done;
    assign InstExMemAddress    = r_addr;
    assign DataExMemAddress    = r_addr;
    assign InstExMemData1      = r_inst1;
    assign InstExMemData2      = r_inst2;
    assign DataExMemData1      = r_data1;
    assign DataExMemData2      = r_data2;

`ifdef LOADER_DUMP_EN
    logic w_out_phase;
    assign w_out_phase = (r_state == ST_DUMP_OUT);

    debug_dump_seq #(
        .DATA_W  (DATA_W),
        .NUM_SEL (NUM_SEL)
    ) u_dump (
        .clk         (clk),
        .reset       (reset),
        .out_phase   (w_out_phase),
        .DebugOutput (DebugOutput),
        .m_ready     (bus.m_ready),
        .m_valid     (bus.m_valid),
        .m_data      (bus.m_data),
        .m_last      (bus.m_last),
        .DebugSel    (DebugSel),
        .word_hs     (w_dump_hs),
        .last_hs     (w_dump_last_hs)
    );
`else
    logic w_unused_dump;
    assign w_dump_hs      = 1'b0;
    assign w_dump_last_hs = 1'b0;
    assign w_unused_dump  = ^{DebugOutput, bus.m_ready, w_dump_hs, w_dump_last_hs};
    assign bus.m_valid    = 1'b0;
    assign bus.m_data     = '0;
    assign bus.m_last     = 1'b0;
    assign DebugSel       = 5'd0;
`endif

endmodule

`default_nettype wire
